pixel_pair_adjust: RTL and testbench

Brightness/contrast stage that sits between the image reader and the image writer. It takes the reader's dual-pixel RGB stream (pixel 0 and pixel 1 per clock, qualified by HSYNC), applies a signed offset and a Q4.4 contrast gain about mid-grey, saturates each channel, and forwards the stream with HSYNC and VSYNC delay-matched. It also counts pairs and clipped samples per frame and pulses frame_done when the last pair leaves.

---
 rtl/pixel_pair_pkg.sv | 45 ++++
 rtl/chan_adjust.sv | 56 +++++
 rtl/pixel_pair_adjust.sv | 180 ++++++++++++++++++
 tb/tb_pixel_pair_adjust.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pair_pkg.sv
// Shared constants, frame-state enum and small helpers for the pixel_pair_adjust stage.
// PIXEL_PAIR_GRAY_OUT_EN selects the extra luma stage and the matching latency.
package pixel_pair_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned NUM_CH  = 6;
  localparam int unsigned D_W     = 11;
  localparam int unsigned PROD_W  = 20;
  localparam int          MID_GREY = 128;
  localparam logic [7:0]  GAIN_ONE = 8'h10;

  localparam int unsigned LUMA_R = 77;
  localparam int unsigned LUMA_G = 150;
  localparam int unsigned LUMA_B = 29;

`ifdef PIXEL_PAIR_GRAY_OUT_EN
  localparam int unsigned LAT = 4;
`else
  localparam int unsigned LAT = 3;
`endif

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StDone
  } frame_state_e;

  function automatic logic [2:0] count_ones6(input logic [5:0] flags);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 6; i++) begin
      n = n + 3'(flags[i]);
    end
    return n;
  endfunction

  function automatic logic [PIX_W-1:0] luma(input logic [PIX_W-1:0] r,
                                            input logic [PIX_W-1:0] g,
                                            input logic [PIX_W-1:0] b);
    logic [15:0] sum;
    sum = 16'(LUMA_R) * 16'(r) + 16'(LUMA_G) * 16'(g) + 16'(LUMA_B) * 16'(b);
    return 8'(sum >> 8);
  endfunction

endpackage

// File: rtl/chan_adjust.sv
// One colour channel: offset about mid-grey (S1), Q4.4 gain (S2), re-centre and clamp (S3).
module chan_adjust
  import pixel_pair_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [PIX_W-1:0]  pix_i,
  input  logic signed [8:0] offset_i,
  input  logic [7:0]        gain_i,
  output logic [PIX_W-1:0]  pix_o,
  output logic              clip_o
);

  logic signed [D_W-1:0]    d_d, d_q;
  logic [7:0]               gain_q;
  logic signed [PROD_W-1:0] prod, m_d, m_q, v;
  logic [PIX_W-1:0]         pix_d, pix_q;
  logic                     clip_d, clip_q;

  always_comb begin
    d_d  = $signed({3'b000, pix_i}) + D_W'(offset_i) - D_W'(MID_GREY);
    prod = PROD_W'(d_q) * $signed({12'b0, gain_q});
    m_d  = prod >>> 4;
    v    = m_q + PROD_W'(MID_GREY);
    pix_d  = v[PIX_W-1:0];
    clip_d = 1'b0;
    if (v[PROD_W-1]) begin
      pix_d  = '0;
      clip_d = 1'b1;
    end else if (|v[PROD_W-2:PIX_W]) begin
      pix_d  = '1;
      clip_d = 1'b1;
    end
  end

  // Gain travels with its sample so S2 always uses the setting the sample entered with.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_q    <= '0;
      gain_q <= '0;
      m_q    <= '0;
      pix_q  <= '0;
      clip_q <= 1'b0;
    end else begin
      d_q    <= d_d;
      gain_q <= gain_i;
      m_q    <= m_d;
      pix_q  <= pix_d;
      clip_q <= clip_d;
    end
  end

  assign pix_o  = pix_q;
  assign clip_o = clip_q;

endmodule

// File: rtl/pixel_pair_adjust.sv
// Dual-pixel brightness/contrast stage with delay-matched syncs, per-frame counters and
// frame_done FSM. Define PIXEL_PAIR_GRAY_OUT_EN to add a luma output stage (LAT 4).
module pixel_pair_adjust
  import pixel_pair_pkg::*;
#(
  parameter int unsigned WIDTH  = 768,
  parameter int unsigned HEIGHT = 512,
  parameter int unsigned CNT_W  = 20
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              VSYNC_IN,
  input  logic              HSYNC_IN,
  input  logic [7:0]        DATA_R0_IN,
  input  logic [7:0]        DATA_G0_IN,
  input  logic [7:0]        DATA_B0_IN,
  input  logic [7:0]        DATA_R1_IN,
  input  logic [7:0]        DATA_G1_IN,
  input  logic [7:0]        DATA_B1_IN,
  input  logic signed [8:0] offset,
  input  logic [7:0]        gain,
  output logic              VSYNC_OUT,
  output logic              HSYNC_OUT,
  output logic [7:0]        DATA_R0_OUT,
  output logic [7:0]        DATA_G0_OUT,
  output logic [7:0]        DATA_B0_OUT,
  output logic [7:0]        DATA_R1_OUT,
  output logic [7:0]        DATA_G1_OUT,
  output logic [7:0]        DATA_B1_OUT,
  output logic              frame_done,
  output logic [CNT_W-1:0]  pair_cnt,
  output logic [CNT_W-1:0]  clip_cnt
);

  localparam logic [CNT_W-1:0] PAIRS_PER_FRAME = CNT_W'(WIDTH * HEIGHT / 2);

  logic              vs_prev_q, vs_rise;
  logic signed [8:0] offset_q, offset_eff;
  logic [7:0]        gain_q, gain_eff;
  logic [LAT-1:0]    hs_q, vs_q;

  logic [PIX_W-1:0]  pix_in  [NUM_CH];
  logic [PIX_W-1:0]  pix_s3  [NUM_CH];
  logic [PIX_W-1:0]  pix_out [NUM_CH];
  logic [NUM_CH-1:0] clip_s3, clip_out;

  logic [CNT_W-1:0]  pair_cnt_q, pair_cnt_d, clip_cnt_q, clip_cnt_d;
  logic [CNT_W:0]    clip_sum;
  logic [2:0]        n_clip;
  frame_state_e      state_q, state_d;

  assign vs_rise = VSYNC_IN & ~vs_prev_q;
  // New settings apply from the rising-edge cycle itself, so a frame is uniformly adjusted.
  assign offset_eff = vs_rise ? offset : offset_q;
  assign gain_eff   = vs_rise ? gain : gain_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vs_prev_q <= 1'b0;
      offset_q  <= '0;
      gain_q    <= GAIN_ONE;
      hs_q      <= '0;
      vs_q      <= '0;
    end else begin
      vs_prev_q <= VSYNC_IN;
      offset_q  <= offset_eff;
      gain_q    <= gain_eff;
      hs_q      <= {hs_q[LAT-2:0], HSYNC_IN};
      vs_q      <= {vs_q[LAT-2:0], VSYNC_IN};
    end
  end

  assign pix_in[0] = DATA_R0_IN;
  assign pix_in[1] = DATA_G0_IN;
  assign pix_in[2] = DATA_B0_IN;
  assign pix_in[3] = DATA_R1_IN;
  assign pix_in[4] = DATA_G1_IN;
  assign pix_in[5] = DATA_B1_IN;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    chan_adjust u_chan (
      .clk_i    (HCLK),
      .rst_ni   (HRESETn),
      .pix_i    (pix_in[i]),
      .offset_i (offset_eff),
      .gain_i   (gain_eff),
      .pix_o    (pix_s3[i]),
      .clip_o   (clip_s3[i])
    );
  end

`ifdef PIXEL_PAIR_GRAY_OUT_EN
  logic [PIX_W-1:0]  y_q [2];
  logic [NUM_CH-1:0] clip_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      y_q[0] <= '0;
      y_q[1] <= '0;
      clip_q <= '0;
    end else begin
      y_q[0] <= luma(pix_s3[0], pix_s3[1], pix_s3[2]);
      y_q[1] <= luma(pix_s3[3], pix_s3[4], pix_s3[5]);
      clip_q <= clip_s3;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pix_out[i] = y_q[i / 3];
    end
    clip_out = clip_q;
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pix_out[i] = pix_s3[i];
    end
    clip_out = clip_s3;
  end
`endif

  assign HSYNC_OUT   = hs_q[LAT-1];
  assign VSYNC_OUT   = vs_q[LAT-1];
  assign DATA_R0_OUT = HSYNC_OUT ? pix_out[0] : '0;
  assign DATA_G0_OUT = HSYNC_OUT ? pix_out[1] : '0;
  assign DATA_B0_OUT = HSYNC_OUT ? pix_out[2] : '0;
  assign DATA_R1_OUT = HSYNC_OUT ? pix_out[3] : '0;
  assign DATA_G1_OUT = HSYNC_OUT ? pix_out[4] : '0;
  assign DATA_B1_OUT = HSYNC_OUT ? pix_out[5] : '0;

  assign n_clip = count_ones6(clip_out);

  // Frame-start clear wins over the increment; the coincident pair opens the new frame.
  always_comb begin
    clip_sum   = {1'b0, clip_cnt_q} + (CNT_W + 1)'(n_clip);
    pair_cnt_d = pair_cnt_q;
    clip_cnt_d = clip_cnt_q;
    if (vs_rise) begin
      pair_cnt_d = CNT_W'(HSYNC_OUT);
      clip_cnt_d = HSYNC_OUT ? CNT_W'(n_clip) : '0;
    end else if (HSYNC_OUT) begin
      pair_cnt_d = (&pair_cnt_q) ? pair_cnt_q : pair_cnt_q + CNT_W'(1);
      clip_cnt_d = clip_sum[CNT_W] ? '1 : clip_sum[CNT_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (vs_rise) state_d = StActive;
      end
      StActive: begin
        if (!vs_rise && HSYNC_OUT && pair_cnt_d == PAIRS_PER_FRAME) state_d = StDone;
      end
      StDone: begin
        state_d = vs_rise ? StActive : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pair_cnt_q <= '0;
      clip_cnt_q <= '0;
      state_q    <= StIdle;
    end else begin
      pair_cnt_q <= pair_cnt_d;
      clip_cnt_q <= clip_cnt_d;
      state_q    <= state_d;
    end
  end

  assign pair_cnt   = pair_cnt_q;
  assign clip_cnt   = clip_cnt_q;
  assign frame_done = (state_q == StDone);

endmodule

// File: tb/tb_pixel_pair_adjust.sv
// Randomised scoreboard bench for pixel_pair_adjust (small 4x2 frame so frame_done fires often).
module tb_pixel_pair_adjust;

`ifdef PIXEL_PAIR_GRAY_OUT_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  localparam int W = 4;
  localparam int H = 2;
  localparam int CW = 20;
  localparam int PAIRS = W * H / 2;
  localparam int CAP = (1 << CW) - 1;

  typedef struct {
    logic [47:0] px;
    int          nclip;
  } exp_t;

  logic              HCLK = 1'b0;
  logic              HRESETn = 1'b0;
  logic              VSYNC_IN = 1'b0, HSYNC_IN = 1'b0;
  logic [7:0]        DATA_R0_IN = '0, DATA_G0_IN = '0, DATA_B0_IN = '0;
  logic [7:0]        DATA_R1_IN = '0, DATA_G1_IN = '0, DATA_B1_IN = '0;
  logic signed [8:0] offset = '0;
  logic [7:0]        gain = 8'h10;
  logic              VSYNC_OUT, HSYNC_OUT, frame_done;
  logic [7:0]        DATA_R0_OUT, DATA_G0_OUT, DATA_B0_OUT, DATA_R1_OUT, DATA_G1_OUT, DATA_B1_OUT;
  logic [CW-1:0]     pair_cnt, clip_cnt;

  pixel_pair_adjust #(.WIDTH(W), .HEIGHT(H), .CNT_W(CW)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .VSYNC_IN    (VSYNC_IN),
    .HSYNC_IN    (HSYNC_IN),
    .DATA_R0_IN  (DATA_R0_IN),
    .DATA_G0_IN  (DATA_G0_IN),
    .DATA_B0_IN  (DATA_B0_IN),
    .DATA_R1_IN  (DATA_R1_IN),
    .DATA_G1_IN  (DATA_G1_IN),
    .DATA_B1_IN  (DATA_B1_IN),
    .offset      (offset),
    .gain        (gain),
    .VSYNC_OUT   (VSYNC_OUT),
    .HSYNC_OUT   (HSYNC_OUT),
    .DATA_R0_OUT (DATA_R0_OUT),
    .DATA_G0_OUT (DATA_G0_OUT),
    .DATA_B0_OUT (DATA_B0_OUT),
    .DATA_R1_OUT (DATA_R1_OUT),
    .DATA_G1_OUT (DATA_G1_OUT),
    .DATA_B1_OUT (DATA_B1_OUT),
    .frame_done  (frame_done),
    .pair_cnt    (pair_cnt),
    .clip_cnt    (clip_cnt)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int failures = 0;

  // Reference state
  exp_t        exp_q[$];
  logic [1:0]  sync_q[$];
  logic        mon_en = 1'b0;
  logic        cur_rise = 1'b0;
  logic        m_vs_prev = 1'b0;
  int          m_off = 0, m_gain = 16;
  int          m_cnt = 0, m_clip = 0;
  logic        m_pending = 1'b0, m_done = 1'b0;
  logic [47:0] cur_px = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int floor_div16(input int p);
    return (p >= 0) ? p / 16 : -((-p + 15) / 16);
  endfunction

  function automatic exp_t model(input logic [47:0] px, input int off, input int gn);
    exp_t e;
    int   v[6];
    e.nclip = 0;
    for (int i = 0; i < 6; i++) begin
      v[i] = floor_div16((int'(px[8*i +: 8]) - 128 + off) * gn) + 128;
      if (v[i] < 0) begin
        v[i] = 0;
        e.nclip++;
      end else if (v[i] > 255) begin
        v[i] = 255;
        e.nclip++;
      end
    end
`ifdef PIXEL_PAIR_GRAY_OUT_EN
    for (int p = 0; p < 2; p++) begin
      int y;
      y = (77 * v[3*p] + 150 * v[3*p+1] + 29 * v[3*p+2]) / 256;
      for (int k = 0; k < 3; k++) v[3*p+k] = y;
    end
`endif
    for (int i = 0; i < 6; i++) e.px[8*i +: 8] = 8'(v[i]);
    return e;
  endfunction

  function automatic logic [47:0] pk(input int r0, input int g0, input int b0,
                                     input int r1, input int g1, input int b1);
    return {8'(b1), 8'(g1), 8'(r1), 8'(b0), 8'(g0), 8'(r0)};
  endfunction

  function automatic logic [7:0] rpix();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return 8'd0;
    if (sel == 1) return 8'd255;
    return 8'($urandom_range(0, 255));
  endfunction

  // One input cycle; called at posedge+1, returns at next posedge+1.
  task automatic step(input logic vs, input logic hs, input logic [47:0] px);
    logic rise;
    VSYNC_IN = vs;
    HSYNC_IN = hs;
    {DATA_B1_IN, DATA_G1_IN, DATA_R1_IN, DATA_B0_IN, DATA_G0_IN, DATA_R0_IN} = px;
    rise = vs && !m_vs_prev;
    m_vs_prev = vs;
    if (rise) begin
      m_off  = int'(offset);
      m_gain = int'(gain);
    end
    cur_rise = rise;
    if (hs) exp_q.push_back(model(px, m_off, m_gain));
    sync_q.push_back({vs, hs});
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  task automatic do_reset(input logic check_now);
    mon_en   = 1'b0;
    HRESETn  = 1'b0;
    VSYNC_IN = 1'b0;
    HSYNC_IN = 1'b0;
    #1;
    if (check_now) begin
      chk("rst_hsync_out", 64'(HSYNC_OUT), 64'd0);
      chk("rst_vsync_out", 64'(VSYNC_OUT), 64'd0);
      chk("rst_data", 64'({DATA_B1_OUT, DATA_G1_OUT, DATA_R1_OUT,
                           DATA_B0_OUT, DATA_G0_OUT, DATA_R0_OUT}), 64'd0);
      chk("rst_pair_cnt", 64'(pair_cnt), 64'd0);
      chk("rst_clip_cnt", 64'(clip_cnt), 64'd0);
      chk("rst_frame_done", 64'(frame_done), 64'd0);
    end
    repeat (2) @(posedge HCLK);
    #1;
    exp_q.delete();
    sync_q.delete();
    for (int i = 0; i < LAT; i++) sync_q.push_back(2'b00);
    m_vs_prev = 1'b0;
    m_off = 0;
    m_gain = 16;
    m_cnt = 0;
    m_clip = 0;
    m_pending = 1'b0;
    m_done = 1'b0;
    cur_rise = 1'b0;
    HRESETn = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: every cycle compare syncs/counters; pop a scoreboard entry on each output pair.
  logic [1:0]  mon_s;
  exp_t        mon_e;
  logic        mon_hs;
  int          mon_nclip;
  logic [47:0] got;

  always @(negedge HCLK) begin
    if (mon_en) begin
      chk("frame_done", 64'(frame_done), 64'(m_done));
      chk("pair_cnt", 64'(pair_cnt), 64'(m_cnt));
      chk("clip_cnt", 64'(clip_cnt), 64'(m_clip));
      mon_hs = 1'b0;
      mon_nclip = 0;
      if (sync_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sync_queue got=empty exp=entry at %0t", $time);
      end else begin
        mon_s = sync_q.pop_front();
        mon_hs = mon_s[0];
        chk("hsync_out", 64'(HSYNC_OUT), 64'(mon_s[0]));
        chk("vsync_out", 64'(VSYNC_OUT), 64'(mon_s[1]));
      end
      got = {DATA_B1_OUT, DATA_G1_OUT, DATA_R1_OUT, DATA_B0_OUT, DATA_G0_OUT, DATA_R0_OUT};
      if (mon_hs) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pixel_queue got=empty exp=entry at %0t", $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pixels", 64'(got), 64'(mon_e.px));
          mon_nclip = mon_e.nclip;
        end
      end else begin
        chk("gated_data", 64'(got), 64'd0);
      end
      // Frame bookkeeping for what the counters should show after this edge.
      m_done = 1'b0;
      if (cur_rise) begin
        m_cnt = mon_hs ? 1 : 0;
        m_clip = mon_hs ? mon_nclip : 0;
        m_pending = 1'b1;
      end else if (mon_hs) begin
        m_cnt = (m_cnt + 1 > CAP) ? CAP : m_cnt + 1;
        m_clip = (m_clip + mon_nclip > CAP) ? CAP : m_clip + mon_nclip;
        if (m_pending && m_cnt == PAIRS) begin
          m_done = 1'b1;
          m_pending = 1'b0;
        end
      end
    end
  end

  task automatic new_frame(input int off, input int gn);
    offset = 9'(off);
    gain = 8'(gn);
    step(1'b1, 1'b0, '0);
  endtask

  initial begin
    do_reset(1'b0);
    idle(2);

    // Identity
    new_frame(0, 16);
    step(1'b0, 1'b1, pk(10, 20, 30, 200, 128, 255));
    idle(LAT + 1);

    // Offset and clipping
    new_frame(100, 16);
    step(1'b0, 1'b1, pk(200, 0, 100, 155, 156, 27));
    idle(1);
    new_frame(-256, 16);
    step(1'b0, 1'b1, pk(50, 255, 128, 0, 1, 254));
    idle(LAT + 1);

    // Contrast
    new_frame(0, 32);
    step(1'b0, 1'b1, pk(160, 64, 63, 128, 191, 192));
    idle(1);
    new_frame(0, 8);
    step(1'b0, 1'b1, pk(0, 255, 128, 1, 2, 3));
    idle(LAT + 1);

    // Shadowing: mid-frame gain change only takes effect at the next frame start
    new_frame(0, 16);
    step(1'b0, 1'b1, pk(160, 96, 128, 200, 40, 10));
    gain = 8'h20;
    step(1'b0, 1'b1, pk(160, 96, 128, 200, 40, 10));
    idle(1);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, pk(160, 96, 128, 200, 40, 10));
    idle(LAT + 2);

    // Frame done on 4th pair, 5th pair counts without a pulse
    new_frame(0, 16);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, pk(i, 2 * i, 3 * i, 250, 5, 128));
    idle(LAT + 2);

    // Reset mid-frame, then a normal frame
    new_frame(37, 24);
    step(1'b0, 1'b1, pk(1, 2, 3, 4, 5, 6));
    step(1'b0, 1'b1, pk(250, 2, 3, 4, 5, 6));
    idle(2);
    do_reset(1'b1);
    new_frame(0, 16);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, pk(7, 8, 9, 10, 11, 12 + i));
    idle(LAT + 2);

    // Random frames
    for (int f = 0; f < 60; f++) begin
      int len;
      if ($urandom_range(0, 1) == 1) offset = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 1) == 1) gain = 8'($urandom_range(0, 255));
      step(1'b1, 1'b0, '0);
      if ($urandom_range(0, 3) == 0) begin
        cur_px = {rpix(), rpix(), rpix(), rpix(), rpix(), rpix()};
        step(1'b1, 1'($urandom_range(0, 1)), cur_px);
      end
      len = $urandom_range(1, 8);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 5) == 0) offset = 9'($urandom_range(0, 511));
        if ($urandom_range(0, 5) == 0) gain = 8'($urandom_range(0, 255));
        cur_px = {rpix(), rpix(), rpix(), rpix(), rpix(), rpix()};
        step(1'b0, ($urandom_range(0, 3) != 0), cur_px);
      end
    end
    idle(LAT + 4);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
